signed_mul_sequencer: RTL and testbench



---
 rtl/signed_mul_sequencer_pkg.sv | 22 ++
 rtl/signed_mul_sequencer_if.sv | 33 +++
 rtl/signed_mul_sequencer_twos_abs.sv | 22 ++
 rtl/signed_mul_sequencer.sv | 168 ++++++++++++++++
 tb/tb_signed_mul_sequencer.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/signed_mul_sequencer_pkg.sv
// Shared types and helpers for the signed multiply sequencer.
//   state_t   : sequencer FSM states
//   WDOG_W    : width of the RUN-cycle watchdog counter (TIMEOUT <= 255)
//   twos_neg  : two's-complement negate on a wide word; callers cast the
//               result down to their own width, so any W <= NEG_W works.
package signed_mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    HOLD = 2'd3
  } state_t;

  localparam int WDOG_W = 8;
  localparam int NEG_W  = 64;

  function automatic logic [NEG_W-1:0] twos_neg(input logic [NEG_W-1:0] v);
    return ~v + NEG_W'(1);
  endfunction

endpackage

// File: rtl/signed_mul_sequencer_if.sv
// Bundle of the sequencer's operand stream, product stream and the
// control/data lines toward the unsigned shift-add multiplier.
//   slave  : the sequencer's view
//   master : the environment's view (host side plus multiplier side)
interface signed_mul_sequencer_if #(
  parameter int N = 11,
  parameter int M = 12
);
  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     a;
  logic [M-1:0]     b;
  logic             out_valid;
  logic             out_ready;
  logic [N+M-1:0]   p;
  logic             err;
  logic             m_reset;
  logic             m_mul;
  logic [N-1:0]     m_x;
  logic [M-1:0]     m_y;
  logic [N+M-1:0]   m_z;
  logic             m_done;

  modport slave (
    input  in_valid, a, b, out_ready, m_z, m_done,
    output in_ready, out_valid, p, err, m_reset, m_mul, m_x, m_y
  );

  modport master (
    output in_valid, a, b, out_ready, m_z, m_done,
    input  in_ready, out_valid, p, err, m_reset, m_mul, m_x, m_y
  );
endinterface

// File: rtl/signed_mul_sequencer_twos_abs.sv
// Two's-complement magnitude of a W-bit signed value.
//   i_val  : signed input
//   o_mag  : |i_val| as W-bit unsigned (the most negative value maps to
//            2^(W-1), which still fits unsigned W bits)
//   o_sign : sign bit of i_val
module twos_abs
  import signed_mul_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0] i_val,
  output logic [W-1:0] o_mag,
  output logic         o_sign
);

  logic [W-1:0] w_neg;

  assign w_neg  = W'(twos_neg(NEG_W'(i_val)));
  assign o_sign = i_val[W-1];
  assign o_mag  = o_sign ? w_neg : i_val;

endmodule

// File: rtl/signed_mul_sequencer.sv
// Signed front/back end for the unsigned shift-add multiplier.
// Takes signed a/b over valid/ready, hands magnitudes to the multiplier,
// waits for done, re-applies the sign and returns p over valid/ready.
// A watchdog aborts a RUN that never sees done and pulses err.
//   clk, reset : clock and asynchronous active-high reset
//   bus        : operand/product streams and multiplier control (slave)
// All outputs on bus are registered.
module signed_mul_sequencer
  import signed_mul_pkg::*;
#(
  parameter int N       = 11,
  parameter int M       = 12,
  parameter int TIMEOUT = 63
) (
  input  logic                   clk,
  input  logic                   reset,
  signed_mul_sequencer_if.slave  bus
);

  localparam int P_W = N + M;
  localparam logic [WDOG_W-1:0] TIMEOUT_W = WDOG_W'(TIMEOUT);

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_in_ready, w_in_ready_nxt;
  logic              r_out_valid, w_out_valid_nxt;
  logic [P_W-1:0]    r_p, w_p_nxt;
  logic              r_err, w_err_nxt;
  logic              r_m_reset, w_m_reset_nxt;
  logic              r_m_mul, w_m_mul_nxt;
  logic [N-1:0]      r_m_x, w_m_x_nxt;
  logic [M-1:0]      r_m_y, w_m_y_nxt;
  logic              r_neg, w_neg_nxt;
  logic [WDOG_W-1:0] r_wdog, w_wdog_nxt;

  logic [N-1:0]      w_mag_a;
  logic [M-1:0]      w_mag_b;
  logic              w_sign_a;
  logic              w_sign_b;
  logic [P_W-1:0]    w_z_neg;
  logic [WDOG_W-1:0] w_wdog_inc;

  twos_abs #(.W(N)) u_abs_a (
    .i_val  (bus.a),
    .o_mag  (w_mag_a),
    .o_sign (w_sign_a)
  );

  twos_abs #(.W(M)) u_abs_b (
    .i_val  (bus.b),
    .o_mag  (w_mag_b),
    .o_sign (w_sign_b)
  );

  // Negating zero wraps back to zero, so neg=1 with z=0 still yields 0.
  assign w_z_neg    = P_W'(twos_neg(NEG_W'(bus.m_z)));
  assign w_wdog_inc = r_wdog + WDOG_W'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_in_ready_nxt  = r_in_ready;
    w_out_valid_nxt = r_out_valid;
    w_p_nxt         = r_p;
    w_err_nxt       = 1'b0;
    w_m_reset_nxt   = r_m_reset;
    w_m_mul_nxt     = r_m_mul;
    w_m_x_nxt       = r_m_x;
    w_m_y_nxt       = r_m_y;
    w_neg_nxt       = r_neg;
    w_wdog_nxt      = r_wdog;

    case (r_state)
      IDLE: begin
        if (bus.in_valid && r_in_ready) begin
          w_m_x_nxt      = w_mag_a;
          w_m_y_nxt      = w_mag_b;
          w_neg_nxt      = w_sign_a ^ w_sign_b;
          w_in_ready_nxt = 1'b0;
          // Releasing the multiplier reset here gives it its load cycle
          // in LOAD with mul still low.
          w_m_reset_nxt  = 1'b0;
          w_wdog_nxt     = '0;
          w_state_nxt    = LOAD;
        end
      end

      LOAD: begin
        w_m_mul_nxt = 1'b1;
        w_state_nxt = RUN;
      end

      RUN: begin
        w_wdog_nxt = w_wdog_inc;
        if (bus.m_done) begin
          w_p_nxt         = r_neg ? w_z_neg : bus.m_z;
          w_out_valid_nxt = 1'b1;
          w_m_mul_nxt     = 1'b0;
          w_state_nxt     = HOLD;
        end else if (w_wdog_inc == TIMEOUT_W) begin
          w_err_nxt      = 1'b1;
          w_m_reset_nxt  = 1'b1;
          w_m_mul_nxt    = 1'b0;
          w_in_ready_nxt = 1'b1;
          w_wdog_nxt     = '0;
          w_state_nxt    = IDLE;
        end
      end

      HOLD: begin
        if (bus.out_ready) begin
          w_out_valid_nxt = 1'b0;
          // Resetting the multiplier clears its done before the next LOAD.
          w_m_reset_nxt   = 1'b1;
          w_in_ready_nxt  = 1'b1;
          w_state_nxt     = IDLE;
        end
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_p         <= '0;
      r_err       <= 1'b0;
      r_m_reset   <= 1'b1;
      r_m_mul     <= 1'b0;
      r_m_x       <= '0;
      r_m_y       <= '0;
      r_neg       <= 1'b0;
      r_wdog      <= '0;
    end else begin
      r_in_ready  <= w_in_ready_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_p         <= w_p_nxt;
      r_err       <= w_err_nxt;
      r_m_reset   <= w_m_reset_nxt;
      r_m_mul     <= w_m_mul_nxt;
      r_m_x       <= w_m_x_nxt;
      r_m_y       <= w_m_y_nxt;
      r_neg       <= w_neg_nxt;
      r_wdog      <= w_wdog_nxt;
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.p         = r_p;
  assign bus.err       = r_err;
  assign bus.m_reset   = r_m_reset;
  assign bus.m_mul     = r_m_mul;
  assign bus.m_x       = r_m_x;
  assign bus.m_y       = r_m_y;

endmodule

// File: tb/tb_signed_mul_sequencer.sv
module tb_signed_mul_sequencer;

  localparam int N       = 11;
  localparam int M       = 12;
  localparam int P_W     = N + M;
  localparam int TIMEOUT = 63;
  localparam int MUL_CYC = 2 * N;
  localparam int LAT_MAX = 2 * N + 5;

  typedef struct {
    logic [N-1:0]   a;
    logic [M-1:0]   b;
    logic [N-1:0]   mx;
    logic [M-1:0]   my;
    logic [P_W-1:0] p;
    int             hold;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  signed_mul_sequencer_if #(.N(N), .M(M)) bus ();

  signed_mul_sequencer #(.N(N), .M(M), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Behavioural stand-in for the unsigned shift-add multiplier.
  logic             mdl_stuck = 1'b0;
  logic             mdl_done  = 1'b0;
  logic [P_W-1:0]   mdl_z     = '0;
  logic [N-1:0]     mdl_x     = '0;
  logic [M-1:0]     mdl_y     = '0;
  int               mdl_cnt   = 0;

  always @(posedge clk) begin
    if (bus.m_reset) begin
      mdl_done <= 1'b0;
      mdl_cnt  <= 0;
    end else if (!bus.m_mul) begin
      mdl_x   <= bus.m_x;
      mdl_y   <= bus.m_y;
      mdl_cnt <= 0;
    end else if (!mdl_done && !mdl_stuck) begin
      mdl_cnt <= mdl_cnt + 1;
      if (mdl_cnt == MUL_CYC - 1) begin
        mdl_done <= 1'b1;
        mdl_z    <= P_W'(mdl_x) * P_W'(mdl_y);
      end
    end
  end

  assign bus.m_done = mdl_done;
  assign bus.m_z    = mdl_z;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic run_op(input vec_t v, input string tag);
    int   lat;
    logic got;
    logic ready_leak;
    logic hold_ok;
    logic [P_W-1:0] p_seen;

    @(negedge clk);
    bus.a         = v.a;
    bus.b         = v.b;
    bus.in_valid  = 1'b1;
    bus.out_ready = (v.hold == 0);
    @(posedge clk); #1;
    chk({tag, " accept in_ready"}, bus.in_ready, 0);
    chk({tag, " m_x"}, bus.m_x, v.mx);
    chk({tag, " m_y"}, bus.m_y, v.my);
    bus.in_valid = 1'b0;
    bus.a        = N'($urandom);
    bus.b        = M'($urandom);

    lat = 0; got = 1'b0; ready_leak = 1'b0;
    while (!got && lat < LAT_MAX + 2) begin
      @(posedge clk); #1;
      lat++;
      if (bus.out_valid) got = 1'b1;
      if (bus.in_ready) ready_leak = 1'b1;
    end
    chk({tag, " out_valid seen"}, got, 1);
    chk({tag, " latency in range"}, (lat >= 4 && lat <= LAT_MAX), 1);
    chk({tag, " in_ready low while busy"}, ready_leak, 0);
    chk({tag, " p"}, bus.p, v.p);

    p_seen  = bus.p;
    hold_ok = 1'b1;
    for (int i = 0; i < v.hold; i++) begin
      @(posedge clk); #1;
      if (bus.p !== p_seen || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1)
        hold_ok = 1'b0;
    end
    if (v.hold > 0) chk({tag, " hold stable"}, hold_ok, 1);

    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk({tag, " done out_valid"}, bus.out_valid, 0);
    chk({tag, " done in_ready"}, bus.in_ready, 1);
    chk({tag, " done m_reset"}, bus.m_reset, 1);
  endtask

  vec_t vecs[10];

  initial begin
    int   err_cnt;
    int   err_at;
    logic ov_seen;
    logic ready_at_err;
    logic mreset_at_err;
    vec_t v;

    vecs[0] = '{a: N'(5),     b: M'(7),     mx: N'(5),    my: M'(7),    p: P_W'(35),       hold: 0};
    vecs[1] = '{a: N'(-3),    b: M'(100),   mx: N'(3),    my: M'(100),  p: P_W'(-300),     hold: 0};
    vecs[2] = '{a: N'(-1),    b: M'(-1),    mx: N'(1),    my: M'(1),    p: P_W'(1),        hold: 0};
    vecs[3] = '{a: N'(-1024), b: M'(-2048), mx: N'(1024), my: M'(2048), p: P_W'(2097152),  hold: 0};
    vecs[4] = '{a: N'(0),     b: M'(-5),    mx: N'(0),    my: M'(5),    p: P_W'(0),        hold: 0};
    vecs[5] = '{a: N'(6),     b: M'(-6),    mx: N'(6),    my: M'(6),    p: P_W'(-36),      hold: 10};
    vecs[6] = '{a: N'(-7),    b: M'(7),     mx: N'(7),    my: M'(7),    p: P_W'(-49),      hold: 0};
    vecs[7] = '{a: N'(1023),  b: M'(2047),  mx: N'(1023), my: M'(2047), p: P_W'(2094081),  hold: 0};
    vecs[8] = '{a: N'(-1024), b: M'(2047),  mx: N'(1024), my: M'(2047), p: P_W'(-2096128), hold: 0};
    vecs[9] = '{a: N'(1),     b: M'(-2048), mx: N'(1),    my: M'(2048), p: P_W'(-2048),    hold: 3};

    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    #1;
    chk("reset in_ready", bus.in_ready, 1);
    chk("reset out_valid", bus.out_valid, 0);
    chk("reset p", bus.p, 0);
    chk("reset err", bus.err, 0);
    chk("reset m_reset", bus.m_reset, 1);
    chk("reset m_mul", bus.m_mul, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i], $sformatf("vec%0d", i));
    end

    // Multiplier never finishes: watchdog abort.
    mdl_stuck = 1'b1;
    @(negedge clk);
    bus.a = N'(3); bus.b = M'(3); bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    err_cnt = 0; err_at = -1; ov_seen = 1'b0;
    ready_at_err = 1'b0; mreset_at_err = 1'b0;
    for (int c = 1; c <= TIMEOUT + 20; c++) begin
      @(posedge clk); #1;
      if (bus.out_valid) ov_seen = 1'b1;
      if (bus.err) begin
        err_cnt++;
        if (err_at < 0) begin
          err_at        = c;
          ready_at_err  = bus.in_ready;
          mreset_at_err = bus.m_reset;
        end
      end
    end
    chk("wdog err pulses", err_cnt, 1);
    chk("wdog err cycle", err_at, TIMEOUT + 1);
    chk("wdog in_ready", ready_at_err, 1);
    chk("wdog m_reset", mreset_at_err, 1);
    chk("wdog no out_valid", ov_seen, 0);
    mdl_stuck = 1'b0;

    // Reset in the middle of RUN.
    @(negedge clk);
    bus.a = N'(9); bus.b = M'(-9); bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    chk("pre-reset m_mul", bus.m_mul, 1);
    reset = 1'b1;
    #1;
    chk("midrun in_ready", bus.in_ready, 1);
    chk("midrun out_valid", bus.out_valid, 0);
    chk("midrun p", bus.p, 0);
    chk("midrun err", bus.err, 0);
    chk("midrun m_reset", bus.m_reset, 1);
    chk("midrun m_mul", bus.m_mul, 0);
    chk("midrun m_x", bus.m_x, 0);
    chk("midrun m_y", bus.m_y, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    v = '{a: N'(2), b: M'(3), mx: N'(2), my: M'(3), p: P_W'(6), hold: 0};
    run_op(v, "post-reset");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
